// File: rtl/rou_inject.sv
// rou_inject: request injector feeding a roubus ring node.
//
// Requests arriving on a valid/ready interface are buffered in a DEPTH-entry
// FIFO. The head entry is presented on rou_out as a flit {kind, cmd, addr, data}
// and held until the node answers on ack_out (accept > error > retry).
// A retry blanks the flit for BACKOFF cycles before re-presenting it; after
// MAXRETRY retries the flit is dropped.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready = FIFO not full)
//   req_kind/cmd/addr/data request fields (kind 0 is ignored)
//   rou_out               flit to the ring node, all-zero when idle
//   ack_out               {error, retry, accept} from the ring node
//   done_valid/done_status retirement pulse: 0 ok, 2 error, 3 dropped
//   sent_count            accepted flits, wrapping 16-bit counter
module rou_inject #(
  parameter int DWID     = 128,
  parameter int AWID     = 32,
  parameter int CWID     = 8,
  parameter int WID      = 2 + DWID + AWID + CWID,
  parameter int DEPTH    = 4,
  parameter int BACKOFF  = 4,
  parameter int MAXRETRY = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [CWID-1:0] req_cmd,
  input  logic [AWID-1:0] req_addr,
  input  logic [DWID-1:0] req_data,
  output logic [WID-1:0]  rou_out,
  input  logic [2:0]      ack_out,
  output logic            done_valid,
  output logic [1:0]      done_status,
  output logic [15:0]     sent_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(MAXRETRY + 1);
  localparam int BW = $clog2(BACKOFF + 1);

  localparam logic [CW-1:0] CFULL = CW'(DEPTH);
  localparam logic [RW-1:0] RLAST = RW'(MAXRETRY - 1);
  localparam logic [BW-1:0] BLOAD = BW'(BACKOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_BACKOFF
  } state_t;

  state_t state, state_nxt;

  logic [WID-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [WID-1:0] head;
  logic           push, pop;

  logic [RW-1:0]  retry_cnt, retry_nxt;
  logic [BW-1:0]  bo_cnt, bo_nxt;
  logic [WID-1:0] rou_nxt;
  logic           dv_nxt;
  logic [1:0]     ds_nxt;
  logic [15:0]    sent_nxt;

  assign req_ready = (count != CFULL);
  assign push      = req_valid && req_ready && (req_kind != 2'd0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {req_kind, req_cmd, req_addr, req_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rou_out     <= '0;
      done_valid  <= 1'b0;
      done_status <= 2'd0;
      sent_count  <= '0;
      retry_cnt   <= '0;
      bo_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      rou_out     <= rou_nxt;
      done_valid  <= dv_nxt;
      done_status <= ds_nxt;
      sent_count  <= sent_nxt;
      retry_cnt   <= retry_nxt;
      bo_cnt      <= bo_nxt;
    end
  end

  // Outputs are computed here as next-state values and registered above,
  // so rou_out/done_* change only on the clock edge.
  always_comb begin
    state_nxt = state;
    rou_nxt   = rou_out;
    dv_nxt    = 1'b0;
    ds_nxt    = 2'd0;
    sent_nxt  = sent_count;
    retry_nxt = retry_cnt;
    bo_nxt    = bo_cnt;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          rou_nxt   = head;
          retry_nxt = '0;
          state_nxt = S_SEND;
        end else begin
          rou_nxt = '0;
        end
      end
      S_SEND: begin
        if (ack_out[0]) begin
          pop       = 1'b1;
          dv_nxt    = 1'b1;
          ds_nxt    = 2'd0;
          sent_nxt  = sent_count + 16'd1;
          rou_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (ack_out[2]) begin
          pop       = 1'b1;
          dv_nxt    = 1'b1;
          ds_nxt    = 2'd2;
          rou_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (ack_out[1]) begin
          rou_nxt = '0;
          if (retry_cnt == RLAST) begin
            pop       = 1'b1;
            dv_nxt    = 1'b1;
            ds_nxt    = 2'd3;
            state_nxt = S_IDLE;
          end else begin
            retry_nxt = retry_cnt + 1'b1;
            bo_nxt    = BLOAD;
            state_nxt = S_BACKOFF;
          end
        end
      end
      S_BACKOFF: begin
        rou_nxt = '0;
        if (bo_cnt == '0) begin
          rou_nxt   = head;
          state_nxt = S_SEND;
        end else begin
          bo_nxt = bo_cnt - 1'b1;
        end
      end
      default: begin
        rou_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rou_inject.sv
// Directed self-checking bench for rou_inject with default parameters.
module tb_rou_inject;

  localparam int WID = 170;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_kind;
  logic [7:0]     req_cmd;
  logic [31:0]    req_addr;
  logic [127:0]   req_data;
  logic [WID-1:0] rou_out;
  logic [2:0]     ack_out;
  logic           done_valid;
  logic [1:0]     done_status;
  logic [15:0]    sent_count;

  int n_checks = 0;
  int n_pass   = 0;

  rou_inject #(
    .DWID(128), .AWID(32), .CWID(8), .DEPTH(4), .BACKOFF(4), .MAXRETRY(7)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
    .rou_out(rou_out), .ack_out(ack_out),
    .done_valid(done_valid), .done_status(done_status), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WID-1:0] got, input logic [WID-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WID-1:0] flit(input logic [1:0] k, input logic [7:0] c,
                                          input logic [31:0] a, input logic [127:0] d);
    return {k, c, a, d};
  endfunction

  task automatic drive(input logic [1:0] k, input logic [7:0] c,
                       input logic [31:0] a, input logic [127:0] d);
    req_kind = k; req_cmd = c; req_addr = a; req_data = d;
  endtask

  task automatic push_one(input logic [1:0] k, input logic [7:0] c,
                          input logic [31:0] a, input logic [127:0] d);
    drive(k, c, a, d);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  logic [WID-1:0] f [5];
  logic [WID-1:0] g;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; ack_out = 3'd0;
    drive(2'd0, 8'd0, 32'd0, 128'd0);
    tick(); tick();
    check("rst_rou", rou_out, '0);
    check("rst_dv", WID'(done_valid), WID'(0));
    check("rst_ds", WID'(done_status), WID'(0));
    check("rst_sent", WID'(sent_count), WID'(0));
    check("rst_ready", WID'(req_ready), WID'(1));
    rst_n = 1'b1;
    tick();

    // Single write: flit visible after two edges, accepted on the third.
    push_one(2'd1, 8'h05, 32'h1000, 128'hAB);
    check("sw_rou_n", rou_out, '0);
    tick();
    check("sw_rou", rou_out, flit(2'd1, 8'h05, 32'h1000, 128'hAB));
    ack_out = 3'b001;
    tick();
    ack_out = 3'b000;
    check("sw_dv", WID'(done_valid), WID'(1));
    check("sw_ds", WID'(done_status), WID'(0));
    check("sw_sent", WID'(sent_count), WID'(1));
    check("sw_rou0", rou_out, '0);
    tick();
    check("sw_dv_off", WID'(done_valid), WID'(0));

    // Fill and backpressure.
    for (int i = 0; i < 5; i++)
      f[i] = flit(2'((i % 3) + 1), 8'(8'h10 + i), 32'(32'h2000 + 4 * i), 128'(128'hC0DE00 + i));
    for (int i = 0; i < 4; i++) begin
      drive(f[i][169:168], f[i][167:160], f[i][159:128], f[i][127:0]);
      req_valid = 1'b1;
      tick();
    end
    check("fill_ready0", WID'(req_ready), WID'(0));
    drive(f[4][169:168], f[4][167:160], f[4][159:128], f[4][127:0]);
    tick();
    check("fill_held_ready", WID'(req_ready), WID'(0));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("order%0d", k), rou_out, f[k]);
      ack_out = 3'b001;
      tick();
      ack_out = 3'b000;
      check($sformatf("fill_dv%0d", k), WID'(done_valid), WID'(1));
      check($sformatf("fill_ds%0d", k), WID'(done_status), WID'(0));
      check($sformatf("fill_gap%0d", k), rou_out, '0);
      if (k == 0) begin
        check("fill_ready1", WID'(req_ready), WID'(1));
        tick();
        req_valid = 1'b0;
        check("fill_refull", WID'(req_ready), WID'(0));
      end else begin
        tick();
      end
    end
    check("fill_sent", WID'(sent_count), WID'(6));
    check("fill_empty", rou_out, '0);

    // Retry twice with backoff, then accept.
    g = flit(2'd2, 8'h33, 32'hDEAD0000, 128'h1234_5678);
    push_one(2'd2, 8'h33, 32'hDEAD0000, 128'h1234_5678);
    tick();
    check("rt_rou", rou_out, g);
    for (int r = 0; r < 2; r++) begin
      ack_out = 3'b010;
      tick();
      ack_out = 3'b000;
      check($sformatf("rt_dv%0d", r), WID'(done_valid), WID'(0));
      for (int b = 0; b < 4; b++) begin
        check($sformatf("rt_bo%0d_%0d", r, b), rou_out, '0);
        tick();
      end
      check($sformatf("rt_back%0d", r), rou_out, g);
    end
    ack_out = 3'b001;
    tick();
    ack_out = 3'b000;
    check("rt_dv", WID'(done_valid), WID'(1));
    check("rt_ds", WID'(done_status), WID'(0));
    check("rt_sent", WID'(sent_count), WID'(7));
    tick();

    // Drop after seven retries.
    g = flit(2'd3, 8'h77, 32'h0000BEEF, 128'h55);
    push_one(2'd3, 8'h77, 32'h0000BEEF, 128'h55);
    tick();
    check("dr_rou", rou_out, g);
    for (int r = 0; r < 7; r++) begin
      ack_out = 3'b010;
      tick();
      ack_out = 3'b000;
      if (r < 6) begin
        check($sformatf("dr_dv%0d", r), WID'(done_valid), WID'(0));
        tick(); tick(); tick(); tick();
        check($sformatf("dr_back%0d", r), rou_out, g);
      end else begin
        check("dr_dv", WID'(done_valid), WID'(1));
        check("dr_ds", WID'(done_status), WID'(3));
        check("dr_rou0", rou_out, '0);
        check("dr_sent", WID'(sent_count), WID'(7));
      end
    end
    tick();
    check("dr_gone", rou_out, '0);

    // Priority: 111 is accept, 110 is error.
    push_one(2'd1, 8'h01, 32'h1, 128'h1);
    tick();
    ack_out = 3'b111;
    tick();
    ack_out = 3'b000;
    check("pr7_dv", WID'(done_valid), WID'(1));
    check("pr7_ds", WID'(done_status), WID'(0));
    check("pr7_sent", WID'(sent_count), WID'(8));
    tick();
    push_one(2'd1, 8'h02, 32'h2, 128'h2);
    tick();
    ack_out = 3'b110;
    tick();
    ack_out = 3'b000;
    check("pr6_dv", WID'(done_valid), WID'(1));
    check("pr6_ds", WID'(done_status), WID'(2));
    check("pr6_sent", WID'(sent_count), WID'(8));
    tick();

    // Accept during BACKOFF is ignored.
    g = flit(2'd2, 8'h03, 32'h3, 128'h3);
    push_one(2'd2, 8'h03, 32'h3, 128'h3);
    tick();
    ack_out = 3'b010;
    tick();
    ack_out = 3'b001;
    for (int b = 0; b < 4; b++) begin
      check($sformatf("bo_ign_rou%0d", b), rou_out, '0);
      tick();
      check($sformatf("bo_ign_dv%0d", b), WID'(done_valid), WID'(0));
    end
    check("bo_ign_back", rou_out, g);
    tick();
    ack_out = 3'b000;
    check("bo_ign_acc", WID'(done_valid), WID'(1));
    check("bo_ign_sent", WID'(sent_count), WID'(9));
    tick();

    // Kind 0 is never pushed.
    push_one(2'd0, 8'hFF, 32'hFFFF, 128'hFF);
    tick(); tick();
    check("kind0", rou_out, '0);

    // Reset while a flit is in flight with three entries queued.
    push_one(2'd1, 8'hA1, 32'hA1, 128'hA1);
    push_one(2'd1, 8'hA2, 32'hA2, 128'hA2);
    push_one(2'd1, 8'hA3, 32'hA3, 128'hA3);
    check("mr_send", rou_out, flit(2'd1, 8'hA1, 32'hA1, 128'hA1));
    rst_n = 1'b0;
    ack_out = 3'b001;
    tick();
    rst_n = 1'b1;
    ack_out = 3'b000;
    check("mr_rou", rou_out, '0);
    check("mr_dv", WID'(done_valid), WID'(0));
    check("mr_ds", WID'(done_status), WID'(0));
    check("mr_sent", WID'(sent_count), WID'(0));
    check("mr_ready", WID'(req_ready), WID'(1));
    tick(); tick();
    check("mr_empty", rou_out, '0);
    check("mr_dv2", WID'(done_valid), WID'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
